// File: rtl/mha_pkg.sv
// Shared types and constants for the MHA tile sequencer: matrix selects, tile payload, FSM states.
package mha_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned TILE   = 16;
    localparam int unsigned LINE_W = 6;
    localparam int unsigned COL_W  = 3;

    typedef enum logic [1:0] {
        MAT_Q = 2'b00,
        MAT_K = 2'b01,
        MAT_V = 2'b10,
        MAT_O = 2'b11
    } mat_sel_e;

    typedef logic [DW-1:0] tile_t [0:TILE-1][0:TILE-1];

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_Q,
        ST_GAP_Q,
        ST_RD_K,
        ST_GAP_K,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_WR_O,
        ST_GAP_O,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/mha_tile_reg.sv
// Load-enable 16x16 element register with asynchronous clear; holds one Q, K or result tile.
module mha_tile_reg
    import mha_pkg::*;
(
    input  logic  I_CLK,
    input  logic  I_RST_N,
    input  logic  I_LD,
    input  tile_t I_D,
    output tile_t O_Q
);

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int r = 0; r < int'(TILE); r++) begin
                for (int c = 0; c < int'(TILE); c++) begin
                    O_Q[r][c] <= '0;
                end
            end
        end else if (I_LD) begin
            O_Q <= I_D;
        end
    end

endmodule

// File: rtl/mha_tile_sequencer.sv
// Walks column tiles of one line block: fetch Q/K from bram_manager, hand to compute, write result to O.
// Optional response timeout enabled by defining TILE_SEQ_TIMEOUT_EN.
module mha_tile_sequencer
    import mha_pkg::*;
`ifdef TILE_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 1023
)
`endif
(
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_START,
    input  logic [LINE_W-1:0] I_LINE,
    input  logic [COL_W-1:0]  I_COL_LAST,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_BM_RD_ENA,
    output logic              O_BM_WR_ENA,
    output logic [1:0]        O_BM_SEL_MAT,
    output logic [LINE_W-1:0] O_BM_SEL_LINE,
    output logic [COL_W-1:0]  O_BM_SEL_COL,
    output tile_t             O_BM_MAT,
    input  logic              I_BM_VLD,
    input  tile_t             I_BM_MAT,
    input  logic              I_BM_WR_DONE,
    output logic              O_TILE_VLD,
    input  logic              I_TILE_RDY,
    output tile_t             O_Q_TILE,
    output tile_t             O_K_TILE,
    input  logic              I_RES_VLD,
    input  tile_t             I_RES_MAT,
    output logic              O_ERR
);

    seq_state_e        state_q, state_nxt;
    logic [LINE_W-1:0] line_q, line_nxt;
    logic [COL_W-1:0]  col_q, col_nxt;
    logic [COL_W-1:0]  last_q, last_nxt;
    mat_sel_e          sel_mat_q, sel_mat_nxt;
    logic              rd_ena_q, rd_ena_nxt;
    logic              wr_ena_q, wr_ena_nxt;
    logic              tile_vld_q, tile_vld_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              ld_q, ld_k, ld_res;

`ifdef TILE_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_nxt;
    logic             tmo_hit;
    logic             err_q, err_nxt;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

    // Tile loads only in the state that expects the response; stray strobes are ignored.
    assign ld_q   = (state_q == ST_RD_Q)     && I_BM_VLD;
    assign ld_k   = (state_q == ST_RD_K)     && I_BM_VLD;
    assign ld_res = (state_q == ST_WAIT_RES) && I_RES_VLD;

    mha_tile_reg u_q_reg (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_LD    (ld_q),
        .I_D     (I_BM_MAT),
        .O_Q     (O_Q_TILE)
    );

    mha_tile_reg u_k_reg (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_LD    (ld_k),
        .I_D     (I_BM_MAT),
        .O_Q     (O_K_TILE)
    );

    mha_tile_reg u_res_reg (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_LD    (ld_res),
        .I_D     (I_RES_MAT),
        .O_Q     (O_BM_MAT)
    );

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            col_q      <= '0;
            last_q     <= '0;
            sel_mat_q  <= MAT_Q;
            rd_ena_q   <= 1'b0;
            wr_ena_q   <= 1'b0;
            tile_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TILE_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            line_q     <= line_nxt;
            col_q      <= col_nxt;
            last_q     <= last_nxt;
            sel_mat_q  <= sel_mat_nxt;
            rd_ena_q   <= rd_ena_nxt;
            wr_ena_q   <= wr_ena_nxt;
            tile_vld_q <= tile_vld_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
`ifdef TILE_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_nxt;
            err_q      <= err_nxt;
`endif
        end
    end

    // Next state, plus output values decoded from the next state so every output is a flop.
    always_comb begin
        state_nxt = state_q;
        line_nxt  = line_q;
        col_nxt   = col_q;
        last_nxt  = last_q;
`ifdef TILE_SEQ_TIMEOUT_EN
        err_nxt   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    state_nxt = ST_RD_Q;
                    line_nxt  = I_LINE;
                    last_nxt  = I_COL_LAST;
                    col_nxt   = '0;
`ifdef TILE_SEQ_TIMEOUT_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            ST_RD_Q: begin
                if (I_BM_VLD) begin
                    state_nxt = ST_GAP_Q;
                end
`ifdef TILE_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
`endif
            end
            ST_GAP_Q: state_nxt = ST_RD_K;
            ST_RD_K: begin
                if (I_BM_VLD) begin
                    state_nxt = ST_GAP_K;
                end
`ifdef TILE_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
`endif
            end
            ST_GAP_K: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (I_TILE_RDY) begin
                    state_nxt = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (I_RES_VLD) begin
                    state_nxt = ST_WR_O;
                end
            end
            ST_WR_O: begin
                if (I_BM_WR_DONE) begin
                    state_nxt = ST_GAP_O;
                end
`ifdef TILE_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end
`endif
            end
            ST_GAP_O: begin
                if (col_q == last_q) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_RD_Q;
                    col_nxt   = col_q + COL_W'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

`ifdef TILE_SEQ_TIMEOUT_EN
        tmo_cnt_nxt = ((state_nxt == state_q) &&
                       (state_q inside {ST_RD_Q, ST_RD_K, ST_WR_O})) ?
                      tmo_cnt_q + TMO_W'(1) : '0;
`endif

        rd_ena_nxt   = (state_nxt == ST_RD_Q) || (state_nxt == ST_RD_K);
        wr_ena_nxt   = (state_nxt == ST_WR_O);
        tile_vld_nxt = (state_nxt == ST_ISSUE);
        done_nxt     = (state_nxt == ST_DONE);
        busy_nxt     = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_RD_K: sel_mat_nxt = MAT_K;
            ST_WR_O: sel_mat_nxt = MAT_O;
            default: sel_mat_nxt = MAT_Q;
        endcase
    end

    assign O_BUSY        = busy_q;
    assign O_DONE        = done_q;
    assign O_BM_RD_ENA   = rd_ena_q;
    assign O_BM_WR_ENA   = wr_ena_q;
    assign O_BM_SEL_MAT  = sel_mat_q;
    assign O_BM_SEL_LINE = line_q;
    assign O_BM_SEL_COL  = col_q;
    assign O_TILE_VLD    = tile_vld_q;

`ifdef TILE_SEQ_TIMEOUT_EN
    assign O_ERR = err_q;
`else
    assign O_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mha_tile_sequencer.sv
// Directed, table-driven bench for mha_tile_sequencer acting as bram_manager and compute stage.
module tb_mha_tile_sequencer;
    import mha_pkg::*;

    logic              I_CLK = 1'b0;
    logic              I_RST_N;
    logic              I_START;
    logic [LINE_W-1:0] I_LINE;
    logic [COL_W-1:0]  I_COL_LAST;
    logic              O_BUSY, O_DONE, O_BM_RD_ENA, O_BM_WR_ENA;
    logic [1:0]        O_BM_SEL_MAT;
    logic [LINE_W-1:0] O_BM_SEL_LINE;
    logic [COL_W-1:0]  O_BM_SEL_COL;
    tile_t             O_BM_MAT;
    logic              I_BM_VLD;
    tile_t             I_BM_MAT;
    logic              I_BM_WR_DONE;
    logic              O_TILE_VLD;
    logic              I_TILE_RDY;
    tile_t             O_Q_TILE, O_K_TILE;
    logic              I_RES_VLD;
    tile_t             I_RES_MAT;
    logic              O_ERR;

    mha_tile_sequencer dut (
        .I_CLK         (I_CLK),
        .I_RST_N       (I_RST_N),
        .I_START       (I_START),
        .I_LINE        (I_LINE),
        .I_COL_LAST    (I_COL_LAST),
        .O_BUSY        (O_BUSY),
        .O_DONE        (O_DONE),
        .O_BM_RD_ENA   (O_BM_RD_ENA),
        .O_BM_WR_ENA   (O_BM_WR_ENA),
        .O_BM_SEL_MAT  (O_BM_SEL_MAT),
        .O_BM_SEL_LINE (O_BM_SEL_LINE),
        .O_BM_SEL_COL  (O_BM_SEL_COL),
        .O_BM_MAT      (O_BM_MAT),
        .I_BM_VLD      (I_BM_VLD),
        .I_BM_MAT      (I_BM_MAT),
        .I_BM_WR_DONE  (I_BM_WR_DONE),
        .O_TILE_VLD    (O_TILE_VLD),
        .I_TILE_RDY    (I_TILE_RDY),
        .O_Q_TILE      (O_Q_TILE),
        .O_K_TILE      (O_K_TILE),
        .I_RES_VLD     (I_RES_VLD),
        .I_RES_MAT     (I_RES_MAT),
        .O_ERR         (O_ERR)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [LINE_W-1:0] line;
        logic [COL_W-1:0]  col_last;
        int                bm_lat;
        int                rdy_hold;
        int                res_lat;
        logic [7:0]        q_base;
        logic [7:0]        k_base;
        logic [7:0]        r_base;
        bit                uniform;
        bit                noise;
        int                exp_done_cyc;
    } vec_t;

    vec_t vecs [4];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic logic [7:0] pat(input logic [7:0] base, input int col,
                                       input int r, input int c, input bit uni);
        int v;
        v = int'(base) + col * 8;
        if (!uni) v = v + r * 3 + c * 5;
        return 8'(v);
    endfunction

    task automatic fill(output tile_t t, input logic [7:0] base, input int col, input bit uni);
        for (int r = 0; r < int'(TILE); r++)
            for (int c = 0; c < int'(TILE); c++)
                t[r][c] = pat(base, col, r, c, uni);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_tile(input string name, input tile_t act, input logic [7:0] base,
                            input int col, input bit uni);
        int         bad = -1;
        logic [7:0] ea = '0;
        logic [7:0] ee = '0;
        for (int r = 0; r < int'(TILE); r++)
            for (int c = 0; c < int'(TILE); c++)
                if (bad < 0 && act[r][c] !== pat(base, col, r, c, uni)) begin
                    bad = r * int'(TILE) + c;
                    ea  = act[r][c];
                    ee  = pat(base, col, r, c, uni);
                end
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s @%0t: element %0d got %0h expected %0h", name, $time, bad, ea, ee);
        end
    endtask

    task automatic step();
        @(negedge I_CLK);
        cyc++;
    endtask

    // Drives one full start..done sequence as bram_manager + compute, checking at every cycle.
    task automatic run_seq(input vec_t v);
        tile_t t;
        tile_t omem [8];
        int    ncol;
        ncol = int'(v.col_last) + 1;
        I_START = 1'b1; I_LINE = v.line; I_COL_LAST = v.col_last; cyc = 0;
        step();
        I_START = 1'b0;
        chk("busy_after_start", 32'(O_BUSY), 32'd1);
        for (int c = 0; c < ncol; c++) begin
            for (int m = 0; m < 2; m++) begin
                chk("rd_ena", 32'(O_BM_RD_ENA), 32'd1);
                chk("wr_ena_in_rd", 32'(O_BM_WR_ENA), 32'd0);
                chk("rd_sel_mat", 32'(O_BM_SEL_MAT), 32'(m));
                chk("rd_sel_line", 32'(O_BM_SEL_LINE), 32'(v.line));
                chk("rd_sel_col", 32'(O_BM_SEL_COL), 32'(c));
                for (int i = 1; i < v.bm_lat; i++) begin
                    step();
                    chk("rd_hold_ena", 32'(O_BM_RD_ENA), 32'd1);
                    chk("rd_hold_col", 32'(O_BM_SEL_COL), 32'(c));
                end
                fill(t, (m == 0) ? v.q_base : v.k_base, c, v.uniform);
                I_BM_MAT = t; I_BM_VLD = 1'b1;
                step();
                I_BM_VLD = 1'b0;
                chk("rd_gap_quiet", 32'({O_BM_RD_ENA, O_BM_WR_ENA, O_TILE_VLD}), 32'd0);
                step();
            end
            for (int i = 0; i <= v.rdy_hold; i++) begin
                chk("issue_vld", 32'(O_TILE_VLD), 32'd1);
                chk("issue_rd_ena", 32'(O_BM_RD_ENA), 32'd0);
                chk_tile("issue_q_tile", O_Q_TILE, v.q_base, c, v.uniform);
                chk_tile("issue_k_tile", O_K_TILE, v.k_base, c, v.uniform);
                I_TILE_RDY = (i == v.rdy_hold);
                if (v.noise && i == 0 && v.rdy_hold > 0) begin
                    I_START = 1'b1; I_LINE = ~v.line;
                    fill(t, 8'hEE, 0, 1'b1);
                    I_RES_MAT = t; I_RES_VLD = 1'b1;
                end
                step();
                I_TILE_RDY = 1'b0; I_START = 1'b0; I_LINE = v.line; I_RES_VLD = 1'b0;
            end
            for (int i = 0; i <= v.res_lat; i++) begin
                chk("wait_quiet", 32'({O_BM_RD_ENA, O_BM_WR_ENA, O_TILE_VLD}), 32'd0);
                if (i == v.res_lat) begin
                    fill(t, v.r_base, c, v.uniform);
                    I_RES_MAT = t; I_RES_VLD = 1'b1;
                end else if (v.noise && i == 0) begin
                    fill(t, 8'hAA, 0, 1'b1);
                    I_BM_MAT = t; I_BM_VLD = 1'b1; I_BM_WR_DONE = 1'b1;
                end
                step();
                I_RES_VLD = 1'b0; I_BM_VLD = 1'b0; I_BM_WR_DONE = 1'b0;
            end
            chk("wr_ena", 32'(O_BM_WR_ENA), 32'd1);
            chk("rd_ena_in_wr", 32'(O_BM_RD_ENA), 32'd0);
            chk("wr_sel_mat", 32'(O_BM_SEL_MAT), 32'd3);
            chk("wr_sel_line", 32'(O_BM_SEL_LINE), 32'(v.line));
            chk("wr_sel_col", 32'(O_BM_SEL_COL), 32'(c));
            chk_tile("wr_o_mat", O_BM_MAT, v.r_base, c, v.uniform);
            chk_tile("wr_q_kept", O_Q_TILE, v.q_base, c, v.uniform);
            for (int i = 1; i < v.bm_lat; i++) begin
                step();
                chk("wr_hold_ena", 32'(O_BM_WR_ENA), 32'd1);
            end
            omem[c] = O_BM_MAT;
            I_BM_WR_DONE = 1'b1;
            step();
            I_BM_WR_DONE = 1'b0;
            chk("wr_gap_quiet", 32'({O_BM_RD_ENA, O_BM_WR_ENA, O_TILE_VLD, O_DONE}), 32'd0);
            step();
        end
        chk("done_pulse", 32'(O_DONE), 32'd1);
        chk("done_busy", 32'(O_BUSY), 32'd1);
        chk("done_cycle", 32'(cyc), 32'(v.exp_done_cyc));
        chk("done_err", 32'(O_ERR), 32'd0);
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        chk("idle_done_low", 32'(O_DONE), 32'd0);
        chk("idle_busy_low", 32'(O_BUSY), 32'd0);
        step();
        chk("start_in_done_ignored", 32'({O_BUSY, O_BM_RD_ENA}), 32'd0);
        for (int c = 0; c < ncol; c++)
            chk_tile("o_readback", omem[c], v.r_base, c, v.uniform);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tile_t z;
        vecs[0] = '{6'd1,  3'd0, 3, 0, 2, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 17};
        vecs[1] = '{6'd5,  3'd7, 1, 1, 0, 8'h40, 8'h80, 8'h0C, 1'b0, 1'b1, 73};
        vecs[2] = '{6'd63, 3'd0, 2, 5, 1, 8'h55, 8'h66, 8'h77, 1'b1, 1'b0, 18};
        vecs[3] = '{6'd0,  3'd2, 4, 2, 3, 8'hF0, 8'h03, 8'h9A, 1'b0, 1'b1, 67};

        fill(z, 8'h00, 0, 1'b1);
        I_RST_N = 1'b0; I_START = 1'b0; I_LINE = '0; I_COL_LAST = '0;
        I_BM_VLD = 1'b0; I_BM_WR_DONE = 1'b0; I_TILE_RDY = 1'b0; I_RES_VLD = 1'b0;
        I_BM_MAT = z; I_RES_MAT = z;
        repeat (3) step();
        chk("rst_ctrl", 32'({O_BUSY, O_DONE, O_BM_RD_ENA, O_BM_WR_ENA, O_TILE_VLD, O_ERR}), 32'd0);
        chk("rst_sel", 32'({O_BM_SEL_MAT, O_BM_SEL_LINE, O_BM_SEL_COL}), 32'd0);
        chk_tile("rst_q_tile", O_Q_TILE, 8'h00, 0, 1'b1);
        chk_tile("rst_o_mat", O_BM_MAT, 8'h00, 0, 1'b1);
        I_RST_N = 1'b1;
        step();

        for (int i = 0; i < 4; i++) run_seq(vecs[i]);

        // Reset while the K read is outstanding must drop everything at once.
        I_START = 1'b1; I_LINE = 6'd9; I_COL_LAST = 3'd3;
        step();
        I_START = 1'b0;
        fill(z, 8'h21, 0, 1'b1);
        I_BM_MAT = z; I_BM_VLD = 1'b1;
        step();
        I_BM_VLD = 1'b0;
        step();
        chk("pre_rst_rd_k", 32'({O_BM_RD_ENA, O_BM_SEL_MAT}), 32'({1'b1, 2'b01}));
        I_RST_N = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({O_BUSY, O_DONE, O_BM_RD_ENA, O_BM_WR_ENA, O_TILE_VLD}), 32'd0);
        chk("mid_rst_sel", 32'({O_BM_SEL_MAT, O_BM_SEL_LINE, O_BM_SEL_COL}), 32'd0);
        chk_tile("mid_rst_q_tile", O_Q_TILE, 8'h00, 0, 1'b1);
        step();
        chk("mid_rst_hold", 32'({O_BUSY, O_BM_RD_ENA, O_BM_WR_ENA}), 32'd0);
        I_RST_N = 1'b1;
        step();
        chk("post_rst_idle", 32'(O_BUSY), 32'd0);
        run_seq(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
